l2_noc_msg_collector: RTL



---
 rtl/l2_noc_msg_pkg.sv | 27 ++
 rtl/l2_noc_msg_chan.sv | 135 +++++++++++++
 rtl/l2_noc_msg_collector.sv | 76 +++++++
 3 files changed

// File: rtl/l2_noc_msg_pkg.sv
// ---------------------------------------------------------------------------
// l2_noc_msg_pkg
// Shared definitions for the L2 NoC message collector:
//   - per-channel FSM state type
//   - header flit field positions (length and type)
//   - payload flit indices that carry the captured fields
// ---------------------------------------------------------------------------
package l2_noc_msg_pkg;

    typedef enum logic [1:0] {
        IDLE,   // waiting for a header flit
        BODY,   // consuming payload flits
        HOLD    // message presented, waiting for the consumer
    } state_t;

    // Header flit layout
    localparam int LEN_HI  = 29;
    localparam int LEN_LO  = 22;
    localparam int TYPE_HI = 21;
    localparam int TYPE_LO = 14;
    localparam int LEN_W   = LEN_HI - LEN_LO + 1;

    // Payload flit indices (1-based, header excluded)
    localparam logic [LEN_W-1:0] ADDR_FLIT = LEN_W'(1);
    localparam logic [LEN_W-1:0] DATA_FLIT = LEN_W'(2);

endpackage

// File: rtl/l2_noc_msg_chan.sv
// ---------------------------------------------------------------------------
// l2_noc_msg_chan
// One channel of the message collector: reassembles a header flit plus its
// payload flits into a single message record and holds it on a valid/ready
// interface until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flit_valid/ready    flit stream handshake
//   flit_data           raw flit
//   msg_valid/ready     message handshake
//   msg_type/source     header fields
//   msg_tag             tag from the address flit (payload flit 1)
//   msg_data            full data flit (payload flit 2)
//   msg_len             header length field
//   msg_err             header length exceeded MAX_FLITS
//   msg_cnt             delivered-message count, saturating
// ---------------------------------------------------------------------------
module l2_noc_msg_chan
    import l2_noc_msg_pkg::*;
#(
    parameter int FLIT_W    = 64,
    parameter int MAX_FLITS = 8,
    parameter int TYPE_W    = 8,
    parameter int SRC_W     = 6,
    parameter int TAG_W     = 26,
    parameter int TAG_LSB   = 14,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_valid,
    input  logic [FLIT_W-1:0] flit_data,
    output logic              flit_ready,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic [TYPE_W-1:0] msg_type,
    output logic [SRC_W-1:0]  msg_source,
    output logic [TAG_W-1:0]  msg_tag,
    output logic [63:0]       msg_data,
    output logic [LEN_W-1:0]  msg_len,
    output logic              msg_err,
    output logic [CNT_W-1:0]  msg_cnt
);

    state_t           state;
    logic [LEN_W-1:0] remaining;   // payload flits still to come
    logic [LEN_W-1:0] idx;         // 1-based index of the next payload flit
    logic [LEN_W-1:0] hdr_len;
    logic             flit_xfer;

    assign hdr_len   = flit_data[LEN_HI:LEN_LO];
    assign flit_xfer = flit_valid & flit_ready;

    // flit_ready and msg_valid are registered alongside the state so that
    // they change only on state transitions and never glitch combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flit_ready <= 1'b1;
            msg_valid  <= 1'b0;
            msg_type   <= '0;
            msg_source <= '0;
            msg_tag    <= '0;
            msg_data   <= '0;
            msg_len    <= '0;
            msg_err    <= 1'b0;
            msg_cnt    <= '0;
            remaining  <= '0;
            idx        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge register values regardless of statement order.
            case (state)
                IDLE: begin
                    if (flit_xfer) begin
                        msg_type   <= flit_data[TYPE_LO +: TYPE_W];
                        msg_source <= flit_data[SRC_W-1:0];
                        msg_len    <= hdr_len;
                        msg_tag    <= '0;
                        msg_data   <= '0;
                        msg_err    <= (hdr_len > LEN_W'(MAX_FLITS));
                        idx        <= ADDR_FLIT;
                        remaining  <= hdr_len;
                        if (hdr_len == '0) begin
                            state      <= HOLD;
                            flit_ready <= 1'b0;
                            msg_valid  <= 1'b1;
                        end else begin
                            state <= BODY;
                        end
                    end
                end

                BODY: begin
                    if (flit_xfer) begin
                        // Only the address and data flits carry captured
                        // fields; everything else (including flits beyond
                        // MAX_FLITS) is consumed and dropped.
                        if (idx == ADDR_FLIT)
                            msg_tag <= flit_data[TAG_LSB +: TAG_W];
                        if (idx == DATA_FLIT)
                            msg_data <= flit_data[63:0];
                        idx       <= idx + LEN_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state      <= HOLD;
                            flit_ready <= 1'b0;
                            msg_valid  <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Returning to IDLE (rather than accepting a new header
                    // here) gives the mandatory one-cycle gap.
                    if (msg_ready) begin
                        state      <= IDLE;
                        flit_ready <= 1'b1;
                        msg_valid  <= 1'b0;
                        if (msg_cnt != {CNT_W{1'b1}})
                            msg_cnt <= msg_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    flit_ready <= 1'b1;
                    msg_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/l2_noc_msg_collector.sv
// ---------------------------------------------------------------------------
// l2_noc_msg_collector
// Multi-channel NoC message reassembler. Each of NUM_CH channels turns a
// header flit plus payload flits into one abstract message record
// (type, source, tag, data, length, error) on its own valid/ready interface.
// Channels are fully independent; this level only does port packing.
//
// Ports (channel c occupies slice c of every packed vector):
//   clk, rst_n                      clock, asynchronous active-low reset
//   flit_valid/flit_ready [NUM_CH]  flit handshake per channel
//   flit_data  [NUM_CH*FLIT_W]      raw flits
//   msg_valid/msg_ready   [NUM_CH]  message handshake per channel
//   msg_type   [NUM_CH*TYPE_W]      header type
//   msg_source [NUM_CH*SRC_W]       header source
//   msg_tag    [NUM_CH*TAG_W]       tag from the address flit
//   msg_data   [NUM_CH*64]          first data flit
//   msg_len    [NUM_CH*8]           header length
//   msg_err    [NUM_CH]             length overflow flag
//   msg_cnt    [NUM_CH*CNT_W]       delivered-message count, saturating
// ---------------------------------------------------------------------------
module l2_noc_msg_collector
    import l2_noc_msg_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int FLIT_W    = 64,
    parameter int MAX_FLITS = 8,
    parameter int TYPE_W    = 8,
    parameter int SRC_W     = 6,
    parameter int TAG_W     = 26,
    parameter int TAG_LSB   = 14,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        flit_valid,
    input  logic [NUM_CH*FLIT_W-1:0] flit_data,
    output logic [NUM_CH-1:0]        flit_ready,
    output logic [NUM_CH-1:0]        msg_valid,
    input  logic [NUM_CH-1:0]        msg_ready,
    output logic [NUM_CH*TYPE_W-1:0] msg_type,
    output logic [NUM_CH*SRC_W-1:0]  msg_source,
    output logic [NUM_CH*TAG_W-1:0]  msg_tag,
    output logic [NUM_CH*64-1:0]     msg_data,
    output logic [NUM_CH*LEN_W-1:0]  msg_len,
    output logic [NUM_CH-1:0]        msg_err,
    output logic [NUM_CH*CNT_W-1:0]  msg_cnt
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        l2_noc_msg_chan #(
            .FLIT_W    (FLIT_W),
            .MAX_FLITS (MAX_FLITS),
            .TYPE_W    (TYPE_W),
            .SRC_W     (SRC_W),
            .TAG_W     (TAG_W),
            .TAG_LSB   (TAG_LSB),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .flit_valid (flit_valid[c]),
            .flit_data  (flit_data[c*FLIT_W +: FLIT_W]),
            .flit_ready (flit_ready[c]),
            .msg_valid  (msg_valid[c]),
            .msg_ready  (msg_ready[c]),
            .msg_type   (msg_type[c*TYPE_W +: TYPE_W]),
            .msg_source (msg_source[c*SRC_W +: SRC_W]),
            .msg_tag    (msg_tag[c*TAG_W +: TAG_W]),
            .msg_data   (msg_data[c*64 +: 64]),
            .msg_len    (msg_len[c*LEN_W +: LEN_W]),
            .msg_err    (msg_err[c]),
            .msg_cnt    (msg_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule
